// File: rtl/decoder_onehot_seq.sv
// rtl/decoder_onehot_seq.sv - registered N-to-2^N one-hot decoder with direct and scan modes
//
// Purpose:
//   Drives a glitch-free one-hot strobe bus from registered state. In direct
//   mode the select value is captured on a load strobe and held. In scan mode
//   the active line walks from index 0 to OUT_W-1, each index held for
//   dwell+1 cycles, then a one-cycle done pulse is issued.
//
// Optional build macro:
//   DECODER_ONEHOT_SEQ_WRAP_EN - continuous scan. After the last index the
//   walk returns to index 0 with no all-zero gap, done pulses at each wrap,
//   and the scan runs until en_i drops.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active-high, highest priority
//   en_i       global enable; low clears outputs and aborts (no done)
//   mode_i     0 = direct, 1 = scan; only acted on from IDLE
//   load_i     direct-mode strobe, captures sel_in_i
//   sel_in_i   index to decode in direct mode
//   start_i    scan-mode start pulse
//   dwell_i    cycles-minus-one per scan step, captured at start
//   out_o      registered one-hot (or all-zero) decode
//   idx_o      index currently driven on out_o, 0 when out_o is zero
//   busy_o     high while scanning
//   done_o     one-cycle pulse when a scan completes (or wraps)

module decoder_onehot_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  localparam int OUT_W  = 1 << SEL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic               load_i,
  input  logic [SEL_W-1:0]   sel_in_i,
  input  logic               start_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [OUT_W-1:0]   out_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;

    if (!en_i) begin
      // Abort path: never raises done, even on the final scan step.
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // mode decides which strobe acts when load and start coincide.
          if (!mode_i && load_i) begin
            state_d = ST_DIRECT;
            idx_d   = sel_in_i;
          end else if (mode_i && start_i) begin
            state_d = ST_SCAN;
            idx_d   = '0;
            cnt_d   = '0;
            dwell_d = dwell_i;
          end
        end

        ST_DIRECT: begin
          if (!mode_i && load_i) begin
            idx_d = sel_in_i;
          end
        end

        ST_SCAN: begin
          if (cnt_q == dwell_q) begin
            cnt_d = '0;
            if (idx_q == '1) begin
              done_d = 1'b1;
              idx_d  = '0;
`ifdef DECODER_ONEHOT_SEQ_WRAP_EN
              state_d = ST_SCAN;
`else
              state_d = ST_IDLE;
`endif
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are derived from next state so that every port is a flop and
    // out/idx/busy always change on the same edge.
    out_d  = (state_d == ST_IDLE) ? '0 : (OUT_W'(1) << idx_d);
    busy_d = (state_d == ST_SCAN);
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// tb/tb_decoder_onehot_seq.sv - self-checking bench for decoder_onehot_seq
module tb_decoder_onehot_seq;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel_in;
  logic               start;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic [SEL_W-1:0]   idx;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  decoder_onehot_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .load_i(load),
    .sel_in_i(sel_in), .start_i(start), .dwell_i(dwell),
    .out_o(out), .idx_o(idx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; mode = 0; sel_in = '0; dwell = '0;
  endtask

  // Reference: k cycles after the start edge, the active step is k/(dwell+1).
  function automatic int scan_step(int k, int d);
    int s;
    s = k / (d + 1);
`ifdef DECODER_ONEHOT_SEQ_WRAP_EN
    s = s % OUT_W;
`endif
    return s;
  endfunction

  function automatic logic [OUT_W-1:0] scan_out(int k, int d);
    int s;
    s = scan_step(k, d);
    if (s < OUT_W) return OUT_W'(1) << s;
    return '0;
  endfunction

  function automatic logic scan_done(int k, int d);
    int total;
    total = OUT_W * (d + 1);
`ifdef DECODER_ONEHOT_SEQ_WRAP_EN
    return (k > 0) && (k % total == 0);
`else
    return k == total;
`endif
  endfunction

  task automatic test_reset();
    rst = 1; en = 1; mode = 1; start = 1; load = 0; sel_in = '0; dwell = 8'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || idx !== '0) begin
        errors++;
        $display("FAIL reset_cycle%0d out=%h busy=%b done=%b idx=%0d expected all zero", i, out, busy, done, idx);
      end
    end
    rst = 0; start = 0;
    tick();
    checks++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_after out=%h busy=%b done=%b expected zeros", out, busy, done);
    end
  endtask

  task automatic test_direct();
    logic [SEL_W-1:0] exp_idx;
    en = 1; mode = 0; load = 1; sel_in = 3'd5;
    tick();
    checks++;
    if (out !== 8'b0010_0000 || idx !== 3'd5) begin
      errors++;
      $display("FAIL direct_load5 out=%h idx=%0d expected 20 idx 5", out, idx);
    end
    sel_in = 3'd2;
    tick();
    checks++;
    if (out !== 8'b0000_0100 || idx !== 3'd2) begin
      errors++;
      $display("FAIL direct_load2 out=%h idx=%0d expected 04 idx 2", out, idx);
    end
    load = 0;
    for (int i = 0; i < 10; i++) begin
      sel_in = SEL_W'($urandom);
      tick();
      checks++;
      if (out !== 8'b0000_0100) begin
        errors++;
        $display("FAIL direct_hold%0d out=%h expected 04", i, out);
      end
    end
    exp_idx = 3'd2;
    for (int i = 0; i < 30; i++) begin
      load   = 1'($urandom);
      mode   = ($urandom_range(0, 3) == 0);
      start  = 1'($urandom);
      sel_in = SEL_W'($urandom);
      if (load && !mode) exp_idx = sel_in;
      tick();
      checks++;
      if (out !== (OUT_W'(1) << exp_idx) || idx !== exp_idx || busy !== 1'b0) begin
        errors++;
        $display("FAIL direct_rand%0d out=%h idx=%0d busy=%b expected %h idx %0d", i, out, idx, busy, OUT_W'(1) << exp_idx, exp_idx);
      end
    end
    idle_inputs();
    en = 0;
    tick();
    checks++;
    if (out !== '0 || idx !== '0) begin
      errors++;
      $display("FAIL direct_disable out=%h idx=%0d expected 00 idx 0", out, idx);
    end
    en = 1;
  endtask

  task automatic test_scan();
    int dl[$];
    dl = '{2, 0, 255};
    repeat (3) dl.push_back(int'($urandom_range(1, 6)));
    foreach (dl[j]) begin
      int d;
      int total;
      int busy_cnt;
      d = dl[j];
      total = OUT_W * (d + 1);
      busy_cnt = 0;
      en = 1; mode = 1; start = 1; load = 0; dwell = DWELL_W'(d);
      tick();
      for (int k = 0; k <= total; k++) begin
        int s;
        s = scan_step(k, d);
        checks++;
        if (out !== scan_out(k, d) || idx !== ((s < OUT_W) ? SEL_W'(s) : '0) ||
            busy !== (s < OUT_W) || done !== scan_done(k, d)) begin
          errors++;
          $display("FAIL scan_d%0d_k%0d out=%h idx=%0d busy=%b done=%b expected out %h step %0d done %b",
                   d, k, out, idx, busy, done, scan_out(k, d), s, scan_done(k, d));
        end
        if (k < total && busy) busy_cnt++;
        if (k < total) begin
          // Ignored while scanning: start, load, mode, sel_in, dwell.
          start = 1'($urandom); load = 1'($urandom); mode = 1'($urandom);
          sel_in = SEL_W'($urandom); dwell = DWELL_W'($urandom);
        end else begin
          idle_inputs();
        end
        tick();
      end
      checks++;
      if (busy_cnt != total) begin
        errors++;
        $display("FAIL scan_busy_len_d%0d got %0d expected %0d", d, busy_cnt, total);
      end
`ifndef DECODER_ONEHOT_SEQ_WRAP_EN
      checks++;
      if (done !== 1'b0 || out !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL scan_after_done_d%0d out=%h busy=%b done=%b expected zeros", d, out, busy, done);
      end
`endif
      en = 0;
      tick();
      en = 1;
      checks++;
      if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL scan_cleanup_d%0d out=%h busy=%b done=%b expected zeros", d, out, busy, done);
      end
    end
  endtask

  task automatic test_abort();
    int ak[2];
    int d;
    d = 3;
    ak[0] = 6 * (d + 1) + int'($urandom_range(0, d));
    ak[1] = OUT_W * (d + 1) - 1;
    for (int a = 0; a < 2; a++) begin
      idle_inputs();
      en = 1; mode = 1; start = 1; dwell = DWELL_W'(d);
      tick();
      start = 0;
      for (int k = 0; k <= ak[a]; k++) begin
        checks++;
        if (out !== scan_out(k, d) || busy !== 1'b1) begin
          errors++;
          $display("FAIL abort%0d_k%0d out=%h busy=%b expected %h busy 1", a, k, out, busy, scan_out(k, d));
        end
        if (k == ak[a]) en = 0;
        tick();
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out !== '0 || idx !== '0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL abort%0d_after%0d out=%h idx=%0d busy=%b done=%b expected zeros", a, i, out, idx, busy, done);
        end
        en = 1;
        tick();
      end
      mode = 1; start = 1; dwell = DWELL_W'(d);
      tick();
      start = 0;
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (out !== scan_out(k, d) || idx !== SEL_W'(scan_step(k, d)) || busy !== 1'b1) begin
          errors++;
          $display("FAIL abort%0d_restart_k%0d out=%h idx=%0d busy=%b expected %h", a, k, out, idx, busy, scan_out(k, d));
        end
        tick();
      end
      en = 0;
      tick();
      en = 1;
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    en = 1; load = 1; start = 1; mode = 0; sel_in = 3'd6;
    tick();
    checks++;
    if (out !== 8'h40 || idx !== 3'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_direct out=%h idx=%0d busy=%b expected 40 idx 6 busy 0", out, idx, busy);
    end
    en = 0;
    tick();
    en = 1; mode = 1;
    tick();
    checks++;
    if (out !== 8'h01 || idx !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_scan out=%h idx=%0d busy=%b expected 01 idx 0 busy 1", out, idx, busy);
    end
    en = 0; mode = 0;
    tick();
    mode = 1;
    tick();
    checks++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL simul_en_low out=%h busy=%b done=%b expected zeros", out, busy, done);
    end
    idle_inputs();
    en = 1;
    tick();
  endtask

`ifdef DECODER_ONEHOT_SEQ_WRAP_EN
  task automatic test_wrap();
    int d;
    int total;
    int done_cnt;
    d = 1;
    total = OUT_W * (d + 1);
    done_cnt = 0;
    idle_inputs();
    en = 1; mode = 1; start = 1; dwell = DWELL_W'(d);
    tick();
    start = 0;
    for (int k = 0; k <= 2 * total; k++) begin
      checks++;
      if (out !== scan_out(k, d) || busy !== 1'b1 || done !== scan_done(k, d)) begin
        errors++;
        $display("FAIL wrap_k%0d out=%h busy=%b done=%b expected %h done %b", k, out, busy, done, scan_out(k, d), scan_done(k, d));
      end
      if (done) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL wrap_done_count got %0d expected 2", done_cnt);
    end
    en = 0;
    tick();
    checks++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wrap_abort out=%h busy=%b done=%b expected zeros", out, busy, done);
    end
    en = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_abort();
    test_simultaneous();
`ifdef DECODER_ONEHOT_SEQ_WRAP_EN
    test_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_seq.md
Name: decoder_onehot_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. It is the next-generation replacement for the fixed combinational 3-to-8 decoder.
- Adds two modes:
  - Direct mode: the select value is registered on a load strobe.
  - Scan mode: the block walks the active output through all 2^N lines, holding each for a programmable dwell.
- Sits between the control FSMs and chip-select / row-enable fan-out, so that one-hot strobes are glitch-free.

Parameters:
- SEL_W, 3, width of the select input. OUT_W = 2^SEL_W is derived, not overridable.
- DWELL_W, 8, width of the dwell-count input. Each scan step lasts dwell+1 cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global enable; low forces outputs to zero and aborts any operation.
- mode  input  1  0 = direct, 1 = scan. Sampled only in IDLE.
- load  input  1  direct-mode strobe; captures sel_in.
- sel_in  input  SEL_W  index to decode in direct mode.
- start  input  1  scan-mode start pulse.
- dwell  input  DWELL_W  cycles-minus-one per scan step. Sampled at start.
- out  output  OUT_W  registered one-hot (or all-zero) decode.
- idx  output  SEL_W  index currently driven on out. 0 when out is zero.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes normally.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - out=0, idx=0, busy=0, done=0.
  - Dwell counter = 0.
  - rst has priority over all other inputs.
- States:
  - IDLE: out=0.
  - DIRECT: out holds one-hot of the latched index.
  - SCAN: walking.
- Direct mode:
  - Entry: IDLE or DIRECT, with en=1, mode=0 and load=1. On the next edge, out = 1<<sel_in, idx = sel_in, state = DIRECT.
  - Latency is 1 cycle.
  - The value holds until the next load (last load wins) or until en=0.
  - With load=0, out is unchanged.
- Scan mode:
  - Start: IDLE with en=1, mode=1 and start=1. On the next edge, out=1<<0, idx=0, busy=1, dwell latched, counter=0.
  - Step advance: the counter increments each cycle. When counter==latched dwell, idx increments and the counter clears. Each index is therefore visible for exactly dwell+1 cycles.
  - dwell=0: out advances every cycle.
  - Completion: after idx=OUT_W-1 completes its dwell, on the next edge out=0, idx=0, busy=0, done=1 for one cycle, state=IDLE.
  - Total busy time is OUT_W*(dwell+1) cycles.
- Ignored inputs:
  - start while busy.
  - load while busy.
  - mode changes outside IDLE.
  - start when mode=0.
  - load when mode=1.
- en=0 (any state):
  - On the next edge: out=0, idx=0, busy=0, state=IDLE, counter cleared.
  - done is not asserted, even if the abort occurs on the final step.
- Simultaneous events:
  - en=0 overrides load and start.
  - load and start together in IDLE: mode selects which one acts.
- Output invariants:
  - out is always either all-zero or exactly one bit set.
  - out is never combinationally dependent on inputs; every output is a flop.
- Widths and arithmetic:
  - The idx increment in SCAN never wraps in the base build; completion happens at OUT_W-1.
  - The counter compare is unsigned, at DWELL_W bits.

Optional Feature:
- Macro: DECODER_ONEHOT_SEQ_WRAP_EN.
- When defined (continuous scan):
  - After idx=OUT_W-1 completes its dwell, idx wraps to 0 and out=1<<0 on the next edge. There is no all-zero gap.
  - done pulses for one cycle coincident with each wrap.
  - busy stays 1.
  - The scan runs until en=0, which aborts with no done pulse.
- When not defined: one-shot scan as described under Behaviour.

Test Plan:
- Reset/idle: assert rst for 2 cycles during en=1, mode=1, start=1 -> out=0, busy=0, done=0 on the cycle after reset; no scan begins.
- Direct decode: en=1, mode=0, load=1 with sel_in=5 -> next cycle out=8'b0010_0000, idx=5. Then load sel_in=2 -> out=8'b0000_0100. Then hold load=0 for 10 cycles -> out unchanged.
- Scan, dwell=2: start pulse -> out=8'h01 for 3 cycles, then 8'h02 for 3 cycles, ... then 8'h80 for 3 cycles. Next cycle out=0 with done=1 for one cycle; busy high for exactly 24 cycles. A start issued mid-scan has no effect.
- Scan, dwell=0: out walks 01,02,...,80 on consecutive cycles, then 0 with done; busy=8 cycles.
- Abort: scan with dwell=3; drop en when idx=6 -> next cycle out=0, busy=0, and done never pulses. A new start with en=1 restarts cleanly at idx=0.
- Wrap (DECODER_ONEHOT_SEQ_WRAP_EN defined), dwell=1: out goes 80 -> 01 with no zero gap and done pulses at the wrap. Two full rotations observed (done count=2), then en=0 -> out=0.
